// File: rtl/arb_pkg.sv
// Shared constants, state encoding and width helper for the priority arbiter.
package arb_pkg;

  localparam logic ARB_MODE_FIXED = 1'b0;
  localparam logic ARB_MODE_RR    = 1'b1;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Ceiling log2, never less than 1 so it can size a vector directly.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 1;
    while ((64'(1) << w) < 64'(value)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/param_priority_arbiter_if.sv
// Request/grant bundle between the masters and the arbiter.
//   request[N]      : one request line per master
//   mode            : 0 fixed priority, 1 round-robin
//   grant[N]        : one-hot grant, zero when idle
//   grant_valid     : |grant
//   grant_id[IW]    : binary index of the owner, 0 when idle
interface param_priority_arbiter_if #(
  parameter int unsigned N = 4
);

  localparam int unsigned IW = arb_pkg::clog2(N);

  logic [N-1:0]  request;
  logic          mode;
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic [IW-1:0] grant_id;

  modport master (
    output request,
    output mode,
    input  grant,
    input  grant_valid,
    input  grant_id
  );

  modport slave (
    input  request,
    input  mode,
    output grant,
    output grant_valid,
    output grant_id
  );

endinterface

// File: rtl/arb_pick.sv
// Combinational pick of one candidate: lowest index in fixed mode, first index
// at or after start_ptr (wrapping) in round-robin mode.
//   cand[N]        : candidate mask
//   start_ptr[IW]  : round-robin start index, ignored in fixed mode
//   mode           : 0 fixed, 1 round-robin
//   onehot[N]      : chosen candidate, zero when cand is empty
//   index[IW]      : binary index of the chosen candidate
//   any            : cand is non-empty
module arb_pick
  import arb_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = clog2(N)
) (
  input  logic [N-1:0]  cand,
  input  logic [IW-1:0] start_ptr,
  input  logic          mode,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] index,
  output logic          any
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;
  logic [IW-1:0]  start;

  // Duplicate the mask and keep the N-bit window starting at start, so the
  // wrap-around becomes a plain lowest-set-bit scan.
  always_comb begin
    start  = (mode == ARB_MODE_RR) ? start_ptr : '0;
    dbl    = {cand, cand};
    masked = '0;
    for (int j = 0; j < int'(2 * N); j++) begin
      masked[j] = dbl[j] && (j >= int'(start)) && (j < int'(start) + int'(N));
    end
  end

  // Scan downwards so the lowest set position is written last.
  always_comb begin
    onehot = '0;
    index  = '0;
    any    = 1'b0;
    for (int j = int'(2 * N) - 1; j >= 0; j--) begin
      if (masked[j]) begin
        any   = 1'b1;
        index = IW'((j >= int'(N)) ? (j - int'(N)) : j);
      end
    end
    if (any) begin
      onehot[index] = 1'b1;
    end
  end

endmodule

// File: rtl/param_priority_arbiter.sv
// N-requester arbiter with registered one-hot grant, run-time fixed/round-robin
// mode, owner hold while requesting, and a forced rotation after MAX_HOLD cycles.
//   clk, rst           : clock, synchronous active-high reset
//   bus.request[N]     : requests
//   bus.mode           : 0 fixed priority, 1 round-robin
//   bus.grant[N]       : registered one-hot grant
//   bus.grant_valid    : registered |grant
//   bus.grant_id       : registered owner index, 0 when idle
module param_priority_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  param_priority_arbiter_if.slave  bus
);

  localparam int unsigned IW       = clog2(N);
  localparam int unsigned HW       = clog2(MAX_HOLD + 1);
  localparam int unsigned HOLD_SAT = (MAX_HOLD == 0) ? 1 : MAX_HOLD;

  arb_state_e    state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] id_q, id_d;
  logic          valid_q, valid_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [IW-1:0] ptr_q, ptr_d;

  logic [N-1:0]  cand;
  logic [N-1:0]  pick_onehot;
  logic [IW-1:0] pick_index;
  logic          pick_any;

  logic          owner_req;
  logic [N-1:0]  others;
  logic          at_limit;
  logic          do_pick;

  arb_pick #(.N(N), .IW(IW)) u_pick (
    .cand      (cand),
    .start_ptr (ptr_q),
    .mode      (bus.mode),
    .onehot    (pick_onehot),
    .index     (pick_index),
    .any       (pick_any)
  );

  assign owner_req = |(bus.request & grant_q);
  assign others    = bus.request & ~grant_q;
  assign at_limit  = (MAX_HOLD != 0) && (hold_q == HW'(MAX_HOLD));

  // Next-state, candidate mask and next grant.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    id_d    = id_q;
    valid_d = valid_q;
    hold_d  = hold_q;
    ptr_d   = ptr_q;
    cand    = bus.request;
    do_pick = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        grant_d = '0;
        id_d    = '0;
        valid_d = 1'b0;
        do_pick = |bus.request;
      end
      ARB_GRANT: begin
        if (!owner_req) begin
          // Release: hand straight over if anyone else waits.
          if (|bus.request) begin
            do_pick = 1'b1;
          end else begin
            state_d = ARB_IDLE;
            grant_d = '0;
            id_d    = '0;
            valid_d = 1'b0;
            hold_d  = '0;
          end
        end else if (!at_limit) begin
          hold_d = (hold_q == HW'(HOLD_SAT)) ? hold_q : hold_q + 1'b1;
        end else if (|others) begin
          // Hold limit reached with contenders: exclude the owner.
          cand    = others;
          do_pick = 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
        id_d    = '0;
        valid_d = 1'b0;
        hold_d  = '0;
      end
    endcase

    if (do_pick && pick_any) begin
      state_d = ARB_GRANT;
      grant_d = pick_onehot;
      id_d    = pick_index;
      valid_d = 1'b1;
      hold_d  = HW'(1);
      ptr_d   = (pick_index == IW'(N - 1)) ? '0 : pick_index + 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      id_q    <= '0;
      valid_q <= 1'b0;
      hold_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      valid_q <= valid_d;
      hold_q  <= hold_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = valid_q;
  assign bus.grant_id    = id_q;

endmodule
